// File: rtl/pokemon_pkg.sv
// Shared types and constants for the wild-encounter scheduler.
package pokemon_pkg;

  typedef enum logic [1:0] {
    ST_ROAM     = 2'd0,
    ST_REQ      = 2'd1,
    ST_BATTLE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } enc_state_t;

  localparam logic [1:0] MAP_TOWN   = 2'b00;
  localparam logic [1:0] MAP_ROUTE  = 2'b01;
  localparam logic [1:0] MAP_FOREST = 2'b10;
  localparam logic [1:0] MAP_CAVE   = 2'b11;

  localparam int WILD_ID_W = 5;
  localparam logic [WILD_ID_W-1:0] NO_POKE = 5'b00000;

  localparam logic [4:0] STEP_CNT_MAX = 5'd31;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/enc_lfsr.sv
// Free-running 8-bit Galois LFSR; advances every frame, reloads SEED on reset.
module enc_lfsr
  import pokemon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       frameClk,
  input  logic       Reset,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;

  always_ff @(posedge frameClk) begin
    if (!Reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/encounter_ctrl.sv
// Wild-encounter scheduler: grass step counting, req/ack hand-off, battle hold, cooldown.
// Optional repel support is compiled in when ENCOUNTER_REPEL_EN is defined.
module encounter_ctrl
  import pokemon_pkg::*;
#(
  parameter logic [4:0] MIN_STEPS   = 5'd4,
  parameter logic [3:0] STEP_MASK   = 4'hF,
  parameter logic [7:0] COOLDOWN_FR = 8'd60,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter logic [7:0] REPEL_STEPS = 8'd100
) (
  input  logic                 frameClk,
  input  logic                 Reset,
  input  logic [1:0]           curr_map,
  input  logic                 in_grass,
  input  logic                 player_step,
  input  logic [WILD_ID_W-1:0] wild_ID,
  input  logic                 battle_ack,
  input  logic                 battle_done,
  input  logic                 repel_use,
  output logic                 enc_req,
  output logic [WILD_ID_W-1:0] enc_ID,
  output logic                 fight_on,
  output logic                 cooldown
);

  enc_state_t           state_q, state_d;
  logic [4:0]           step_cnt_q, step_cnt_d;
  logic [4:0]           threshold_q, threshold_d;
  logic [WILD_ID_W-1:0] enc_id_q, enc_id_d;
  logic [7:0]           cd_cnt_q, cd_cnt_d;
  logic [1:0]           prev_map_q;
  logic [7:0]           lfsr;
  logic [4:0]           new_threshold;
  logic [4:0]           step_inc;
  logic                 map_changed;
  logic                 grass_step;
  logic                 repel_active;
  logic                 count_step;
  logic                 unused_bits;

  enc_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .frameClk (frameClk),
    .Reset    (Reset),
    .lfsr_o   (lfsr)
  );

  assign new_threshold = MIN_STEPS + {1'b0, lfsr[3:0] & STEP_MASK};
  assign step_inc      = (step_cnt_q == STEP_CNT_MAX) ? STEP_CNT_MAX : step_cnt_q + 5'd1;
  assign map_changed   = (curr_map != prev_map_q);
  assign grass_step    = player_step & in_grass;
  assign count_step    = grass_step & ~repel_active;

`ifdef ENCOUNTER_REPEL_EN
  logic [7:0] repel_cnt_q, repel_cnt_d;

  assign repel_active = (repel_cnt_q != 8'd0);
  assign unused_bits  = ^lfsr[7:4];

  // A fresh repel_use reloads even if a suppressed step lands on the same frame.
  always_comb begin
    repel_cnt_d = repel_cnt_q;
    if (repel_use) begin
      repel_cnt_d = REPEL_STEPS;
    end else if (state_q == ST_ROAM && !map_changed && grass_step && repel_active) begin
      repel_cnt_d = repel_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge frameClk) begin
    if (!Reset) repel_cnt_q <= 8'd0;
    else        repel_cnt_q <= repel_cnt_d;
  end
`else
  assign repel_active = 1'b0;
  assign unused_bits  = ^{lfsr[7:4], repel_use, REPEL_STEPS};
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    threshold_d = threshold_q;
    enc_id_d    = enc_id_q;
    cd_cnt_d    = cd_cnt_q;
    case (state_q)
      ST_ROAM: begin
        // A map change on the same frame as a step restarts the walk; the step is dropped.
        if (map_changed) begin
          step_cnt_d  = 5'd0;
          threshold_d = new_threshold;
        end else if (count_step) begin
          step_cnt_d = step_inc;
          if (step_inc >= threshold_q) begin
            enc_id_d = wild_ID;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (battle_ack) state_d = ST_BATTLE;
      end
      ST_BATTLE: begin
        if (battle_done) begin
          state_d  = ST_COOLDOWN;
          cd_cnt_d = COOLDOWN_FR;
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q == 8'd1) begin
          state_d     = ST_ROAM;
          step_cnt_d  = 5'd0;
          threshold_d = new_threshold;
        end else begin
          cd_cnt_d = cd_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_ROAM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge frameClk) begin
    prev_map_q <= curr_map;
    if (!Reset) begin
      state_q     <= ST_ROAM;
      step_cnt_q  <= 5'd0;
      threshold_q <= MIN_STEPS;
      enc_id_q    <= NO_POKE;
      cd_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      threshold_q <= threshold_d;
      enc_id_q    <= enc_id_d;
      cd_cnt_q    <= cd_cnt_d;
    end
  end

  assign enc_req  = (state_q == ST_REQ);
  assign fight_on = (state_q == ST_REQ) || (state_q == ST_BATTLE);
  assign cooldown = (state_q == ST_COOLDOWN);
  assign enc_ID   = enc_id_q;

endmodule
